controle_banco: RTL and testbench
=================================

# controle_banco

Multicycle sequencer that drives the 8×16-bit register bank (`banco_registradores`) through its read/write ports. It accepts one 16-bit instruction per valid/ready handshake and walks a fixed 4-state FSM: latch the instruction, read operands, compute, write back. It is the only block that drives the bank's `Read1`, `Read2`, `WriteReg`, `WriteData` and `RegWrite` inputs.

## Interface
Parameters: none (widths fixed: 16-bit data, 3-bit register index).

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `instr`  in  16  instruction word; sampled only on handshake.
- `instr_valid`  in  1  `instr` is valid.
- `instr_ready`  out  1  controller can accept; high exactly when state is OCIOSO.
- `done`  out  1  one-cycle pulse in the ESCRITA cycle.
- `erro`  out  1  one-cycle pulse with `done` when the opcode is reserved.
- `Read1`  out  3  bank read address 1 = latched rs1.
- `Read2`  out  3  bank read address 2 = latched rs2.
- `WriteReg`  out  3  bank write address = latched rd.
- `WriteData`  out  16  bank write data = result register.
- `RegWrite`  out  1  bank write enable; the bank writes on the next rising edge.
- `Data1`  in  16  bank read data 1.
- `Data2`  in  16  bank read data 2.

## Operation
- Instruction fields: opcode = `instr[15:13]`, rd = `[12:10]`, rs1 = `[9:7]`, rs2 = `[6:4]`, imm = `[9:0]`.
- Opcodes:
  - 000 NOP: no write.
  - 001 MV: rd ← rs1.
  - 010 ADD: rd ← rs1 + rs2.
  - 011 SUB: rd ← rs1 − rs2.
  - 100 LDI: rd ← zero-extended imm.
  - 101–111 reserved: no write, `erro` pulses.
- Arithmetic is 16-bit modulo 2^16. There is no carry, overflow or flag output. Wrap examples: 0xFFFF+1 = 0x0000; 0−1 = 0xFFFF.
- FSM states and transitions:
  - OCIOSO: `instr_ready`=1. On `instr_valid`&`instr_ready`, latch `instr` and go to LEITURA. Otherwise stay.
  - LEITURA: `Read1`/`Read2` already show the latched rs1/rs2. At the edge, capture `Data1`/`Data2` into `op_a`/`op_b`. Go to EXECUTA.
  - EXECUTA: compute the result from `op_a`, `op_b`, imm and opcode, and register it into `resultado`. Go to ESCRITA.
  - ESCRITA: `RegWrite`=1 only for MV/ADD/SUB/LDI. `done`=1 for every opcode; `erro`=1 for reserved opcodes. Go to OCIOSO.
- `Read1`, `Read2` and `WriteReg` come from the latched instruction and hold stable from LEITURA through ESCRITA.
- rd may equal rs1 or rs2 (e.g. ADD r1,r1,r1). Operands are captured in LEITURA, before the write, so the old value is used.
- `instr_valid` outside OCIOSO is ignored. The instruction is not queued; the requester must hold it until it sees `instr_ready`.

## Timing
- Handshake at edge E. LEITURA occupies cycle E..E+1, EXECUTA E+1..E+2, ESCRITA E+2..E+3. The bank writes at E+3. OCIOSO is re-entered after E+3.
- Throughput: one instruction per 4 cycles. `instr_ready` is low for exactly 3 cycles after acceptance.
- An instruction accepted at E+3, as soon as OCIOSO is re-entered, reads in LEITURA the value written at E+3. There is no hazard and no forwarding is needed.
- Reset values (resetn=0, asynchronous): state = OCIOSO; latched instr, `op_a`, `op_b`, `resultado` = 0. Therefore `instr_ready`=1, `done`=`erro`=`RegWrite`=0, `Read1`=`Read2`=`WriteReg`=0, `WriteData`=0x0000.
- Reset asserted mid-instruction, including during ESCRITA: `RegWrite` drops immediately, the instruction is discarded and no write occurs at the next edge.
- `done`, `erro` and `RegWrite` are pure decodes of registered state and latched opcode. They are glitch-free and exactly one cycle wide.

## Test plan
- LDI r3,0x155 → `WriteReg`=3, `WriteData`=0x0155, `RegWrite`=1 for one cycle 3 edges after the handshake. A following MV r4,r3 writes 0x0155 to r4.
- LDI r1,0x3FF; ADD r2,r1,r1 → r2=0x07FE. Then SUB r5,r0,r1 with r0=0 → r5=0xFC01, showing 16-bit wrap.
- Back-to-back: hold `instr_valid`=1 with 3 instructions. Check `instr_ready` follows the pattern 1,0,0,0,1,0,0,0,…, exactly 3 `done` pulses, and a dependent read sees the prior write.
- Opcode 110 → `done`=1 and `erro`=1 together for one cycle, `RegWrite` stays 0, and all 8 registers are unchanged. NOP behaves the same with `erro`=0.
- Assert `resetn`=0 during ESCRITA of ADD r6 → `RegWrite` drops immediately, r6 keeps its old value, and all outputs equal their reset values.
- `instr_valid` toggling while in LEITURA/EXECUTA → no extra acceptance, and the latched rd/rs fields stay unchanged.

Source files
------------

// File: rtl/controle_banco_if.sv
// Bundle between the sequencer, its instruction source and the 8x16 register bank.
//   instr/instr_valid/instr_ready : one-instruction valid/ready handshake
//   done/erro                     : completion pulse, reserved-opcode pulse
//   Read1/Read2/Data1/Data2       : bank read ports (address out, data back)
//   WriteReg/WriteData/RegWrite   : bank write port
// master: instruction source plus bank (the testbench); slave: controle_banco.
interface controle_banco_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        done;
  logic        erro;
  logic [2:0]  Read1;
  logic [2:0]  Read2;
  logic [2:0]  WriteReg;
  logic [15:0] WriteData;
  logic        RegWrite;
  logic [15:0] Data1;
  logic [15:0] Data2;

  modport master (
    output instr, instr_valid, Data1, Data2,
    input  instr_ready, done, erro, Read1, Read2, WriteReg, WriteData, RegWrite
  );

  modport slave (
    input  instr, instr_valid, Data1, Data2,
    output instr_ready, done, erro, Read1, Read2, WriteReg, WriteData, RegWrite
  );
endinterface

// File: rtl/controle_banco.sv
// Multicycle sequencer for the 8x16-bit register bank. Accepts one instruction per
// handshake and walks OCIOSO -> LEITURA -> EXECUTA -> ESCRITA (4 cycles per instruction).
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : controle_banco_if.slave (handshake, status pulses, bank read/write ports)
// Instruction: opcode[15:13] rd[12:10] rs1[9:7] rs2[6:4] imm[9:0].
module controle_banco (
  input  logic              clock,
  input  logic              resetn,
  controle_banco_if.slave   bus
);

  localparam logic [2:0] OpNop = 3'b000;
  localparam logic [2:0] OpMv  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpLdi = 3'b100;

  typedef enum logic [1:0] {
    StOcioso,
    StLeitura,
    StExecuta,
    StEscrita
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic [15:0] resultado_q, resultado_d;

  logic [2:0] opcode;
  logic       reservado;
  logic       escreve;

  assign opcode    = instr_q[15:13];
  assign reservado = opcode[2] & (opcode[1] | opcode[0]);
  assign escreve   = (opcode != OpNop) && !reservado;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StOcioso;
      instr_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      resultado_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      resultado_q <= resultado_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    resultado_d = resultado_q;
    unique case (state_q)
      StOcioso: begin
        // instr_ready is implied by being in this state
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = StLeitura;
        end
      end
      StLeitura: begin
        // Operands are captured before any write of this instruction, so rd==rs uses old value
        op_a_d  = bus.Data1;
        op_b_d  = bus.Data2;
        state_d = StExecuta;
      end
      StExecuta: begin
        unique case (opcode)
          OpMv:    resultado_d = op_a_q;
          OpAdd:   resultado_d = op_a_q + op_b_q;
          OpSub:   resultado_d = op_a_q - op_b_q;
          OpLdi:   resultado_d = {6'b0, instr_q[9:0]};
          default: resultado_d = '0;
        endcase
        state_d = StEscrita;
      end
      StEscrita: state_d = StOcioso;
      default:   state_d = StOcioso;
    endcase
  end

  // Status and write enable decode only registered state, so reset clears them at once
  assign bus.instr_ready = (state_q == StOcioso);
  assign bus.done        = (state_q == StEscrita);
  assign bus.erro        = (state_q == StEscrita) && reservado;
  assign bus.RegWrite    = (state_q == StEscrita) && escreve;

  assign bus.Read1     = instr_q[9:7];
  assign bus.Read2     = instr_q[6:4];
  assign bus.WriteReg  = instr_q[12:10];
  assign bus.WriteData = resultado_q;

endmodule

// File: tb/tb_controle_banco.sv
// Self-checking bench for controle_banco: table of instructions with hand-derived
// expectations fed through a scoreboard, plus back-to-back, valid-toggling and
// reset-in-write sequences. A behavioural 8x16 bank closes the loop.
module tb_controle_banco;

  logic clock = 1'b0;
  logic resetn;
  logic bank_clr;

  always #5 clock = ~clock;

  controle_banco_if bus ();

  controle_banco dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // Behavioural register bank
  logic [15:0] bank [8];
  always @(posedge clock) begin
    if (bank_clr) begin
      for (int i = 0; i < 8; i++) bank[i] <= '0;
    end else if (bus.RegWrite) begin
      bank[bus.WriteReg] <= bus.WriteData;
    end
  end
  assign bus.Data1 = bank[bus.Read1];
  assign bus.Data2 = bank[bus.Read2];

  typedef struct {
    logic [15:0] instr;
    logic        we;
    logic [2:0]  wr;
    logic [15:0] wd;
    logic        err;
  } vec_t;

  typedef struct {
    logic        we;
    logic [2:0]  wr;
    logic [15:0] wd;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int unsigned cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic void push(input vec_t v, input int unsigned c);
    exp_t e;
    e.we  = v.we;
    e.wr  = v.wr;
    e.wd  = v.wd;
    e.err = v.err;
    e.cyc = c;
    sb.push_back(e);
  endfunction

  // Scoreboard monitor: pops one expectation per done pulse
  exp_t m_e;
  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(sb.size()), 1);
        end else begin
          m_e = sb.pop_front();
          check("erro", 32'(bus.erro), 32'(m_e.err));
          check("regwrite", 32'(bus.RegWrite), 32'(m_e.we));
          check("done_latency", cyc, m_e.cyc);
          if (m_e.we) begin
            check("writereg", 32'(bus.WriteReg), 32'(m_e.wr));
            check("writedata", 32'(bus.WriteData), 32'(m_e.wd));
          end
        end
      end else begin
        check("idle_pulses", {30'b0, bus.RegWrite, bus.erro}, 0);
      end
    end
  end

  task automatic send(input vec_t v, input logic track);
    int k;
    @(negedge clock);
    bus.instr       = v.instr;
    bus.instr_valid = 1'b1;
    k = 0;
    while (bus.instr_ready !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (bus.instr_ready !== 1'b1) check("accept_timeout", 32'(bus.instr_ready), 1);
    else if (track) push(v, cyc + 3);
    @(posedge clock);
    #1 bus.instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sb.size() != 0 || bus.instr_ready !== 1'b1) && k < 40) begin
      @(negedge clock);
      k++;
    end
    check("idle_timeout", 32'(sb.size()), 0);
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_ready"}, 32'(bus.instr_ready), 1);
    check({p, "_pulses"}, {29'b0, bus.done, bus.erro, bus.RegWrite}, 0);
    check({p, "_addrs"}, {23'b0, bus.Read1, bus.Read2, bus.WriteReg}, 0);
    check({p, "_wdata"}, 32'(bus.WriteData), 0);
  endtask

  vec_t        tbl [12];
  vec_t        b2b [3];
  vec_t        v;
  logic [15:0] exp_bank [8];
  int          d0;
  int          idx;
  logic        acc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{16'h8D55, 1'b1, 3'd3, 16'h0155, 1'b0};  // LDI r3,0x155
    tbl[1]  = '{16'h3180, 1'b1, 3'd4, 16'h0155, 1'b0};  // MV r4,r3
    tbl[2]  = '{16'h87FF, 1'b1, 3'd1, 16'h03FF, 1'b0};  // LDI r1,0x3FF
    tbl[3]  = '{16'h4890, 1'b1, 3'd2, 16'h07FE, 1'b0};  // ADD r2,r1,r1
    tbl[4]  = '{16'h7410, 1'b1, 3'd5, 16'hFC01, 1'b0};  // SUB r5,r0,r1
    tbl[5]  = '{16'hDD30, 1'b0, 3'd0, 16'h0000, 1'b1};  // reserved 110
    tbl[6]  = '{16'h18A0, 1'b0, 3'd0, 16'h0000, 1'b0};  // NOP
    tbl[7]  = '{16'h9801, 1'b1, 3'd6, 16'h0001, 1'b0};  // LDI r6,1
    tbl[8]  = '{16'h7C60, 1'b1, 3'd7, 16'hFFFF, 1'b0};  // SUB r7,r0,r6 (0-1)
    tbl[9]  = '{16'h43E0, 1'b1, 3'd0, 16'h0000, 1'b0};  // ADD r0,r7,r6 (FFFF+1)
    tbl[10] = '{16'hA000, 1'b0, 3'd0, 16'h0000, 1'b1};  // reserved 101
    tbl[11] = '{16'hE000, 1'b0, 3'd0, 16'h0000, 1'b1};  // reserved 111
    b2b[0]  = '{16'h8402, 1'b1, 3'd1, 16'h0002, 1'b0};  // LDI r1,2
    b2b[1]  = '{16'h4890, 1'b1, 3'd2, 16'h0004, 1'b0};  // ADD r2,r1,r1
    b2b[2]  = '{16'h6D10, 1'b1, 3'd3, 16'h0002, 1'b0};  // SUB r3,r2,r1
    exp_bank = '{16'h0000, 16'h03FF, 16'h07FE, 16'h0155,
                 16'h0155, 16'hFC01, 16'h0001, 16'hFFFF};

    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    resetn          = 1'b0;
    bank_clr        = 1'b1;
    repeat (2) @(posedge clock);
    #1 check_reset_vals("reset");
    @(negedge clock);
    bank_clr = 1'b0;
    resetn   = 1'b1;

    // Table-driven single instructions
    for (int i = 0; i < 12; i++) send(tbl[i], 1'b1);
    wait_idle();
    for (int r = 0; r < 8; r++) check($sformatf("bank_r%0d", r), 32'(bank[r]), 32'(exp_bank[r]));

    // Back-to-back with instr_valid held high
    d0  = done_cnt;
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (k == 0) begin
        bus.instr       = b2b[0].instr;
        bus.instr_valid = 1'b1;
      end
      check($sformatf("b2b_ready_%0d", k), 32'(bus.instr_ready), 32'(k % 4 == 0));
      acc = (bus.instr_ready === 1'b1) && (idx < 3);
      if (acc) push(b2b[idx], cyc + 3);
      @(posedge clock);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) bus.instr = b2b[idx].instr;
        else bus.instr_valid = 1'b0;
      end
    end
    bus.instr_valid = 1'b0;
    wait_idle();
    check("b2b_done_count", 32'(done_cnt - d0), 3);
    check("b2b_r3", 32'(bank[3]), 32'h0002);

    // instr_valid toggling while busy: ADD r5,r3,r4
    d0 = done_cnt;
    v  = '{16'h55C0, 1'b1, 3'd5, 16'h0157, 1'b0};
    send(v, 1'b1);
    bus.instr       = 16'hFFFF;
    bus.instr_valid = 1'b1;
    for (int p = 0; p < 3; p++) begin
      @(negedge clock);
      check($sformatf("busy_ready_%0d", p), 32'(bus.instr_ready), 0);
      check($sformatf("busy_fields_%0d", p), {23'b0, bus.Read1, bus.Read2, bus.WriteReg},
            {23'b0, 3'd3, 3'd4, 3'd5});
      @(posedge clock);
      #1 bus.instr_valid = (p == 1);
    end
    bus.instr = '0;
    wait_idle();
    check("busy_done_count", 32'(done_cnt - d0), 1);
    check("busy_r5", 32'(bank[5]), 32'h0157);

    // Reset asserted during ESCRITA of ADD r6,r1,r2
    v = '{16'h58A0, 1'b1, 3'd6, 16'h0006, 1'b0};
    send(v, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1 check("pre_reset_regwrite", 32'(bus.RegWrite), 1);
    resetn = 1'b0;
    #1 check_reset_vals("mid_reset");
    @(posedge clock);
    #1 check("reset_r6_kept", 32'(bank[6]), 32'h0001);
    @(negedge clock);
    resetn = 1'b1;

    // Normal operation after reset: LDI r6,0x2AA
    v = '{16'h9AAA, 1'b1, 3'd6, 16'h02AA, 1'b0};
    send(v, 1'b1);
    wait_idle();
    check("post_reset_r6", 32'(bank[6]), 32'h02AA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
